data_mem_dma: RTL and testbench



---
 rtl/data_mem_dma_pkg.sv | 27 ++
 rtl/data_mem_dma_addr_gen.sv | 48 ++++
 rtl/data_mem_dma.sv | 178 +++++++++++++++++
 tb/tb_data_mem_dma.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_dma_pkg.sv
// Shared definitions for the data-memory DMA: FSM states, sign_mask encodings
// and memory geometry.
package data_mem_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_CAPT,
        ST_WR,
        ST_FINISH
    } dma_state_t;

    localparam logic [3:0] SM_NONE     = 4'b0000;
    localparam logic [3:0] SM_BYTE     = 4'b0001;
    localparam logic [3:0] SM_HALF     = 4'b0011;
    localparam logic [3:0] SM_WORD     = 4'b0111;
    localparam int         SM_SIGN_BIT = 3;

    localparam int          DATA_MEM_WORDS = 1024;
    localparam logic [31:0] WORD_BYTES     = 32'd4;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_dma_addr_gen.sv
// Source/destination pointers and remaining word count for the DMA; o_last
// flags the final word so the FSM can leave WR for FINISH.
module dma_addr_gen
    import data_mem_dma_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic [31:0]      o_src,
    output logic [31:0]      o_dst,
    output logic [31:0]      o_src_next,
    output logic [31:0]      o_dst_next,
    output logic             o_last
);

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_src       <= i_src;
            r_dst       <= i_dst;
            r_remaining <= i_len;
        end else if (i_advance) begin
            r_src       <= o_src_next;
            r_dst       <= o_dst_next;
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    assign o_src      = r_src;
    assign o_dst      = r_dst;
    assign o_src_next = r_src + WORD_BYTES;
    assign o_dst_next = r_dst + WORD_BYTES;
    assign o_last     = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/data_mem_dma.sv
// Word-copy DMA mastering the data-memory load/store port via bus_req/bus_gnt.
// Optional DATA_MEM_DMA_FILL_EN adds a constant-fill mode (fill_mode/fill_value).
//   state  | meaning
//   IDLE   | waiting for start
//   REQ    | bus_req high, waiting for bus_gnt
//   RD     | word read presented until memory not stalled
//   CAPT   | capture load data into the write-data register
//   WR     | word write presented until memory not stalled
//   FINISH | wait out post-write stall, then release bus and pulse done
module data_mem_dma
    import data_mem_dma_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef DATA_MEM_DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [3:0]       mem_sign_mask,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_clk_stall
);

    logic        w_fill_in;
    logic [31:0] w_fill_val_in;

`ifdef DATA_MEM_DMA_FILL_EN
    assign w_fill_in     = fill_mode;
    assign w_fill_val_in = fill_value;
`else
    assign w_fill_in     = 1'b0;
    assign w_fill_val_in = '0;
`endif

    dma_state_t  r_state;
    logic        r_fill;
    logic [31:0] r_fill_val;

    logic        w_cmd_ok;
    logic        w_load;
    logic        w_advance;
    logic        w_last;
    logic [31:0] w_src;
    logic [31:0] w_dst;
    logic [31:0] w_src_next;
    logic [31:0] w_dst_next;

    // Fill never reads, so the source alignment is irrelevant there.
    assign w_cmd_ok  = (word_aligned(src_addr) || w_fill_in) && word_aligned(dst_addr);
    assign w_load    = (r_state == ST_IDLE) && start && w_cmd_ok && (len_words != '0);
    assign w_advance = (r_state == ST_WR) && !mem_clk_stall;

    dma_addr_gen #(
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_src      (src_addr),
        .i_dst      (dst_addr),
        .i_len      (len_words),
        .o_src      (w_src),
        .o_dst      (w_dst),
        .o_src_next (w_src_next),
        .o_dst_next (w_dst_next),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_fill         <= 1'b0;
            r_fill_val     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bus_req        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_sign_mask  <= SM_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (!w_cmd_ok) begin
                            err <= 1'b1;
                        end else if (len_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_fill     <= w_fill_in;
                            r_fill_val <= w_fill_val_in;
                            busy       <= 1'b1;
                            bus_req    <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        mem_sign_mask <= SM_WORD;
                        if (r_fill) begin
                            r_state        <= ST_WR;
                            mem_memwrite   <= 1'b1;
                            mem_addr       <= w_dst;
                            mem_write_data <= r_fill_val;
                        end else begin
                            r_state     <= ST_RD;
                            mem_memread <= 1'b1;
                            mem_addr    <= w_src;
                        end
                    end
                end
                ST_RD: begin
                    if (!mem_clk_stall) begin
                        r_state       <= ST_CAPT;
                        mem_memread   <= 1'b0;
                        mem_sign_mask <= SM_NONE;
                    end
                end
                ST_CAPT: begin
                    r_state        <= ST_WR;
                    mem_write_data <= mem_read_data;
                    mem_memwrite   <= 1'b1;
                    mem_addr       <= w_dst;
                    mem_sign_mask  <= SM_WORD;
                end
                ST_WR: begin
                    // Pointers advance on this same edge, so the next request
                    // uses the pre-incremented values.
                    if (!mem_clk_stall) begin
                        if (w_last) begin
                            r_state       <= ST_FINISH;
                            mem_memwrite  <= 1'b0;
                            mem_sign_mask <= SM_NONE;
                        end else if (r_fill) begin
                            mem_addr <= w_dst_next;
                        end else begin
                            r_state      <= ST_RD;
                            mem_memwrite <= 1'b0;
                            mem_memread  <= 1'b1;
                            mem_addr     <= w_src_next;
                        end
                    end
                end
                ST_FINISH: begin
                    if (!mem_clk_stall) begin
                        r_state <= ST_IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dma.sv
// Self-checking bench for data_mem_dma: word-array memory with post-write stall,
// sequential copy reference model, directed and randomized transfers.
module tb_data_mem_dma;
    localparam int LEN_W = 11;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
`ifdef DATA_MEM_DMA_FILL_EN
    logic             fill_mode  = 1'b0;
    logic [31:0]      fill_value = '0;
`endif
    logic             busy, done, err, bus_req;
    logic             bus_gnt = 1'b0;
    logic [31:0]      mem_addr, mem_write_data;
    logic             mem_memread, mem_memwrite;
    logic [3:0]       mem_sign_mask;
    logic [31:0]      mem_read_data = '0;
    logic             mem_clk_stall;

    data_mem_dma #(.LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len_words      (len_words),
`ifdef DATA_MEM_DMA_FILL_EN
        .fill_mode      (fill_mode),
        .fill_value     (fill_value),
`endif
        .busy           (busy),
        .done           (done),
        .err            (err),
        .bus_req        (bus_req),
        .bus_gnt        (bus_gnt),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        load_mem     = 1'b0;
    logic        stall_en     = 1'b0;
    logic        r_post_wr    = 1'b0;
    logic        r_rand_stall = 1'b0;
    int          both_cnt = 0, nogrant_cnt = 0, strobe_cnt = 0, bad_sm_cnt = 0;

    assign mem_clk_stall = r_post_wr | r_rand_stall;

    // Memory: one-cycle busy after every accepted write, load data next cycle.
    always @(posedge clk) begin
        r_post_wr <= 1'b0;
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else if (bus_gnt && !mem_clk_stall) begin
            if (mem_memwrite) begin
                mem[mem_addr[11:2]] <= mem_write_data;
                r_post_wr <= 1'b1;
            end
            if (mem_memread) mem_read_data <= mem[mem_addr[11:2]];
        end
        if (mem_memread && mem_memwrite) both_cnt <= both_cnt + 1;
        if ((mem_memread || mem_memwrite) && !bus_gnt) nogrant_cnt <= nogrant_cnt + 1;
        if (mem_memread || mem_memwrite) strobe_cnt <= strobe_cnt + 1;
        if ((mem_memread || mem_memwrite) && mem_sign_mask != 4'b0111) bad_sm_cnt <= bad_sm_cnt + 1;
    end

    always @(negedge clk) r_rand_stall <= stall_en && ($urandom_range(0, 2) == 0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_model();
        @(negedge clk) load_mem = 1'b1;
        @(negedge clk) load_mem = 1'b0;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input bit fill, input logic [31:0] fval);
        @(negedge clk);
        src_addr  = src;
        dst_addr  = dst;
        len_words = LEN_W'(len);
`ifdef DATA_MEM_DMA_FILL_EN
        fill_mode  = fill;
        fill_value = fval;
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        // Inputs are free to change once the command is taken.
        src_addr = $urandom;
        dst_addr = $urandom;
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int gdel, input bit fill, input logic [31:0] fval,
                            input bit chk_cyc);
        int t0, n_req, budget, both0, ng0, sm0, exp_lat;
        bit seen;
        for (int i = 0; i < len; i++)
            ref_mem[((dst >> 2) + i) & 1023] = fill ? fval : ref_mem[((src >> 2) + i) & 1023];
        both0 = both_cnt; ng0 = nogrant_cnt; sm0 = bad_sm_cnt;
        pulse_start(src, dst, len, fill, fval);
        t0 = cyc;
        chk("busy_after_start", busy, 1);
        n_req = 0; seen = 0; budget = 16 * len + gdel + 50;
        while (!seen && budget > 0) begin
            if (done) seen = 1;
            else begin
                if (bus_req) begin
                    if (n_req >= gdel) bus_gnt = 1'b1;
                    n_req++;
                end
                @(negedge clk);
                budget--;
            end
        end
        chk("xfer_done_seen", seen, 1);
        exp_lat = (fill ? 2 * len : 4 * len) + 2 + gdel;
        if (seen && chk_cyc) chk($sformatf("done_latency_len%0d", len), cyc - t0, exp_lat);
        chk("busy_req_at_done", {busy, bus_req}, 2'b00);
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("rd_wr_overlap", both_cnt - both0, 0);
        chk("strobe_without_gnt", nogrant_cnt - ng0, 0);
        chk("sign_mask_word", bad_sm_cnt - sm0, 0);
        chk($sformatf("mem_words_wrong_%0h_%0h", src, dst), mem_diffs(), 0);
    endtask

    task automatic run_reject(input logic [31:0] src, input logic [31:0] dst, input int len,
                              input bit exp_err, input string tag);
        int err_at, done_at, n_req, str0;
        err_at = -1; done_at = -1; n_req = 0; str0 = strobe_cnt;
        pulse_start(src, dst, len, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (err && err_at < 0) err_at = k;
            if (done && done_at < 0) done_at = k;
            if (bus_req) n_req++;
            @(negedge clk);
        end
        chk({tag, "_err_cycle"}, err_at, exp_err ? 0 : -1);
        chk({tag, "_done_cycle"}, done_at, exp_err ? -1 : 0);
        chk({tag, "_bus_req"}, n_req, 0);
        chk({tag, "_strobes"}, strobe_cnt - str0, 0);
        chk({tag, "_mem"}, mem_diffs(), 0);
    endtask

    initial begin
        int len, gdel, s_idx, d_idx;
        bit found;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctl", {busy, done, err, bus_req, mem_memread, mem_memwrite, mem_sign_mask}, '0);
        chk("reset_data", {mem_addr, mem_write_data}, '0);
        load_model();
        @(negedge clk) rst_n = 1'b1;

        // 4-word copy, immediate grant
        for (int i = 0; i < 4; i++) ref_mem[(32'h100 >> 2) + i] = 32'h11111111 * (i + 1);
        load_model();
        run_xfer(32'h100, 32'h200, 4, 0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("copy4_word%0d", i), mem[(32'h200 >> 2) + i], 32'h11111111 * (i + 1));

        run_reject(32'h102, 32'h200, 4, 1'b1, "src_misaligned");
        run_reject(32'h100, 32'h203, 4, 1'b1, "dst_misaligned");
        run_reject(32'h100, 32'h200, 0, 1'b0, "len_zero");

        // delayed grant
        run_xfer(32'h500, 32'h600, 5, 10, 1'b0, 32'h0, 1'b1);

        // overlapping ascending copy propagates the first word
        ref_mem[32'h100 >> 2] = 32'hA5A5A5A5;
        load_model();
        run_xfer(32'h100, 32'h104, 3, 0, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i <= 3; i++)
            chk($sformatf("overlap_word%0d", i), mem[(32'h100 >> 2) + i], 32'hA5A5A5A5);

`ifdef DATA_MEM_DMA_FILL_EN
        run_xfer(32'h3, 32'h700, 8, 0, 1'b1, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("fill_word%0d", i), mem[(32'h700 >> 2) + i], 32'hDEADBEEF);
`endif

        for (int it = 0; it < 10; it++) begin
            len      = $urandom_range(1, 10);
            gdel     = $urandom_range(0, 4);
            s_idx    = $urandom_range(0, 1023 - len);
            d_idx    = $urandom_range(0, 1023 - len);
            stall_en = $urandom_range(0, 1) == 1;
            run_xfer(32'(s_idx * 4), 32'(d_idx * 4), len, gdel, 1'b0, 32'h0, !stall_en);
        end
        stall_en = 1'b0;
        @(negedge clk);

        // reset during the second word's write
        pulse_start(32'h300, 32'h400, 4, 1'b0, 32'h0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (bus_req) bus_gnt = 1'b1;
            if (mem_memwrite && mem_addr == 32'h404) found = 1;
            else @(negedge clk);
        end
        chk("rst_second_wr_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {busy, done, err, bus_req, mem_memread, mem_memwrite, mem_sign_mask}, '0);
        chk("rst_mid_data", {mem_addr, mem_write_data}, '0);
        @(negedge clk);
        bus_gnt = 1'b0;
        rst_n   = 1'b1;
        ref_mem[32'h400 >> 2] = ref_mem[32'h300 >> 2];
        chk("rst_partial_mem", mem_diffs(), 0);
        run_xfer(32'h300, 32'h480, 2, 0, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
